estagio_escrita: RTL and testbench
==================================

ESTAGIO_ESCRITA -- requirements
Module: estagio_escrita

Interface
REQ-001 The block SHALL have one parameter: bits_palavra, default 3, width of ULA result word.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 entrada_valida  input  1  upstream ULA result and flags present this cycle.
REQ-006 entrada_pronta  output  1  stage can accept an entry this cycle.
REQ-007 resultadoOp  input  bits_palavra  ULA result.
REQ-008 controle  input  5  ULA operation code that produced resultadoOp.
REQ-009 Z, C, S, O  input  1 each  ULA zero, carry, sign, overflow flags.
REQ-010 destino  input  3  destination register index.
REQ-011 descarte  input  1  synchronous flush of buffered entries.
REQ-012 saida_valida  output  1  head entry available downstream.
REQ-013 saida_pronta  input  1  downstream accepts head entry.
REQ-014 resultado_saida  output  bits_palavra  head entry result.
REQ-015 destino_saida  output  3  head entry destination.
REQ-016 flags_Z, flags_C, flags_S, flags_O  output  1 each  architectural flag register.

Function
REQ-017 Push SHALL occur when entrada_valida && entrada_pronta; pop SHALL occur when saida_valida && saida_pronta.
REQ-018 Buffer SHALL be a 2-entry in-order FIFO of {resultadoOp, destino}; FSM states VAZIO, UM, CHEIO.
REQ-019 Transitions: VAZIO+push->UM; UM+push only->CHEIO; UM+pop only->VAZIO; UM+push+pop->UM; CHEIO+pop->UM; otherwise hold.
REQ-020 entrada_pronta SHALL be 1 in VAZIO and UM, 0 in CHEIO, driven from state register only (no combinational path from saida_pronta).
REQ-021 saida_valida SHALL be 1 in UM and CHEIO; resultado_saida/destino_saida SHALL show the oldest entry.
REQ-022 Latency: entry pushed at edge N SHALL appear on outputs with saida_valida=1 after edge N (first cycle after acceptance) when buffer was VAZIO.
REQ-023 Outputs SHALL hold stable while saida_valida=1 and saida_pronta=0.
REQ-024 Flag register SHALL update only on push, from the pushed entry, by controle[4:3]: 00 (arithmetic) -> Z,C,S,O all loaded; 01 (shift) -> Z,S,C loaded, O cleared to 0; 10/11 (logic) -> Z,S loaded, C,O held.
REQ-025 Flags SHALL update in acceptance order, independent of pop timing.
REQ-026 descarte=1 SHALL set state VAZIO at next edge, discard all entries, and leave flag register unchanged.
REQ-027 descarte with simultaneous push: flush wins; pushed entry discarded; flags not updated.
REQ-028 descarte with simultaneous pop: pop is consumed by downstream; state still VAZIO next cycle.
REQ-029 Data in unoccupied slots is don't-care but SHALL NOT be visible while saida_valida=0 (resultado_saida driven 0 in VAZIO).

Reset
REQ-030 reset_n=0 SHALL immediately (asynchronously) force state VAZIO, saida_valida=0, entrada_pronta=1, resultado_saida=0, destino_saida=0, all flags 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; no pop or flag update occurs on the edge it is asserted.
REQ-032 After reset_n rises, first push SHALL be accepted on the first following rising edge.

Verification
REQ-033 Single push: controle=00000, resultadoOp=000, Z=1,C=1,S=0,O=0, destino=2, saida_pronta=1 -> next cycle saida_valida=1, resultado_saida=000, destino_saida=2, flags Z=1 C=1 S=0 O=0; following cycle VAZIO.
REQ-034 Backpressure: saida_pronta=0, push 011 then 111 -> CHEIO, entrada_pronta=0, head 011 held; third push ignored; raise saida_pronta -> 011 then 111 popped in order.
REQ-035 Flag masking: push arithmetic with C=1,O=1, then logic op (controle=10000) with Z=0,S=1,C=0,O=0 -> flags Z=0 S=1 C=1 O=1; then shift (01000) with C=0 -> C=0, O=0.
REQ-036 Simultaneous push+pop in UM for 4 cycles with results 001,010,011,100 -> state stays UM, outputs follow one cycle behind, no entry lost.
REQ-037 descarte while CHEIO with concurrent push of 101 -> next cycle VAZIO, saida_valida=0, flags unchanged from before flush.
REQ-038 reset_n pulled low between edges while CHEIO -> outputs and flags 0 immediately, entrada_pronta=1, no glitch to saida_valida=1 after release.

Source files
------------

// File: rtl/estagio_escrita.sv
// estagio_escrita: write-back stage with a 2-entry in-order FIFO of {result, destination}
// and an architectural flag register that is loaded on accept according to the operation class.
`default_nettype none

module estagio_escrita #(
  parameter int bits_palavra = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    entrada_valida,
  output logic                    entrada_pronta,
  input  logic [bits_palavra-1:0] resultadoOp,
  input  logic [4:0]              controle,
  input  logic                    Z,
  input  logic                    C,
  input  logic                    S,
  input  logic                    O,
  input  logic [2:0]              destino,
  input  logic                    descarte,
  output logic                    saida_valida,
  input  logic                    saida_pronta,
  output logic [bits_palavra-1:0] resultado_saida,
  output logic [2:0]              destino_saida,
  output logic                    flags_Z,
  output logic                    flags_C,
  output logic                    flags_S,
  output logic                    flags_O
);

  localparam logic [1:0] VAZIO = 2'd0;
  localparam logic [1:0] UM    = 2'd1;
  localparam logic [1:0] CHEIO = 2'd2;

  localparam logic [1:0] OP_ARIT  = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;

  logic [1:0]              state_q,    state_d;
  logic [bits_palavra-1:0] head_res_q, head_res_d;
  logic [2:0]              head_dst_q, head_dst_d;
  logic [bits_palavra-1:0] tail_res_q, tail_res_d;
  logic [2:0]              tail_dst_q, tail_dst_d;
  logic                    flag_z_q,   flag_z_d;
  logic                    flag_c_q,   flag_c_d;
  logic                    flag_s_q,   flag_s_d;
  logic                    flag_o_q,   flag_o_d;

  logic push;
  logic pop;
  logic unused_controle;

  // Only the operation class selects which flags load.
  assign unused_controle = ^controle[2:0];

  // Handshakes come straight from the state register, so there is no
  // combinational path from saida_pronta back to entrada_pronta.
  assign entrada_pronta = (state_q != CHEIO);
  assign saida_valida   = (state_q != VAZIO);
  assign push           = entrada_valida && entrada_pronta;
  assign pop            = saida_valida && saida_pronta;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_dst_d = head_dst_q;
    tail_res_d = tail_res_q;
    tail_dst_d = tail_dst_q;

    if (descarte) begin
      state_d = VAZIO;
    end else begin
      case (state_q)
        VAZIO: begin
          if (push) begin
            state_d    = UM;
            head_res_d = resultadoOp;
            head_dst_d = destino;
          end
        end
        UM: begin
          if (push && pop) begin
            head_res_d = resultadoOp;
            head_dst_d = destino;
          end else if (push) begin
            state_d    = CHEIO;
            tail_res_d = resultadoOp;
            tail_dst_d = destino;
          end else if (pop) begin
            state_d = VAZIO;
          end
        end
        CHEIO: begin
          if (pop) begin
            state_d    = UM;
            head_res_d = tail_res_q;
            head_dst_d = tail_dst_q;
          end
        end
        default: state_d = VAZIO;
      endcase
    end
  end

  // Flags follow acceptance order; a flushed push never touches them.
  always_comb begin
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    flag_s_d = flag_s_q;
    flag_o_d = flag_o_q;

    if (push && !descarte) begin
      flag_z_d = Z;
      flag_s_d = S;
      if (controle[4:3] == OP_ARIT) begin
        flag_c_d = C;
        flag_o_d = O;
      end else if (controle[4:3] == OP_SHIFT) begin
        flag_c_d = C;
        flag_o_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= VAZIO;
      head_res_q <= '0;
      head_dst_q <= '0;
      tail_res_q <= '0;
      tail_dst_q <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_s_q   <= 1'b0;
      flag_o_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_dst_q <= head_dst_d;
      tail_res_q <= tail_res_d;
      tail_dst_q <= tail_dst_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      flag_s_q   <= flag_s_d;
      flag_o_q   <= flag_o_d;
    end
  end

  // Stale slot contents stay hidden while the buffer is empty.
  assign resultado_saida = saida_valida ? head_res_q : '0;
  assign destino_saida   = saida_valida ? head_dst_q : 3'd0;

  assign flags_Z = flag_z_q;
  assign flags_C = flag_c_q;
  assign flags_S = flag_s_q;
  assign flags_O = flag_o_q;

endmodule

`default_nettype wire

// File: tb/tb_estagio_escrita.sv
// Directed plus short random bench for estagio_escrita with a queue scoreboard and flag model.
`default_nettype none

module tb_estagio_escrita;

  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         entrada_valida = 1'b0;
  logic         entrada_pronta;
  logic [W-1:0] resultadoOp = '0;
  logic [4:0]   controle = '0;
  logic         Z = 1'b0, C = 1'b0, S = 1'b0, O = 1'b0;
  logic [2:0]   destino = '0;
  logic         descarte = 1'b0;
  logic         saida_valida;
  logic         saida_pronta = 1'b0;
  logic [W-1:0] resultado_saida;
  logic [2:0]   destino_saida;
  logic         flags_Z, flags_C, flags_S, flags_O;

  estagio_escrita #(.bits_palavra(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .entrada_valida(entrada_valida), .entrada_pronta(entrada_pronta),
    .resultadoOp(resultadoOp), .controle(controle),
    .Z(Z), .C(C), .S(S), .O(O), .destino(destino),
    .descarte(descarte),
    .saida_valida(saida_valida), .saida_pronta(saida_pronta),
    .resultado_saida(resultado_saida), .destino_saida(destino_saida),
    .flags_Z(flags_Z), .flags_C(flags_C), .flags_S(flags_S), .flags_O(flags_O)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] res;
    logic [2:0]   dst;
  } entry_t;

  entry_t     sb[$];
  logic [3:0] m_flags = 4'b0000;  // {Z,C,S,O}
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":saida_valida"}, 32'(saida_valida), 32'(sb.size() > 0));
    chk({tag, ":entrada_pronta"}, 32'(entrada_pronta), 32'(sb.size() < 2));
    if (sb.size() > 0) begin
      chk({tag, ":resultado"}, 32'(resultado_saida), 32'(sb[0].res));
      chk({tag, ":destino"}, 32'(destino_saida), 32'(sb[0].dst));
    end else begin
      chk({tag, ":resultado_vazio"}, 32'(resultado_saida), 32'd0);
      chk({tag, ":destino_vazio"}, 32'(destino_saida), 32'd0);
    end
    chk({tag, ":flags"}, 32'({flags_Z, flags_C, flags_S, flags_O}), 32'(m_flags));
  endtask

  // Applies the edge effect of the currently driven inputs to the model.
  task automatic model_edge();
    bit     do_push;
    bit     do_pop;
    entry_t e;
    do_push = entrada_valida && (sb.size() < 2);
    do_pop  = saida_pronta && (sb.size() > 0);
    if (descarte) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.res = resultadoOp;
        e.dst = destino;
        sb.push_back(e);
        case (controle[4:3])
          2'b00:   m_flags = {Z, C, S, O};
          2'b01:   m_flags = {Z, C, S, 1'b0};
          default: m_flags = {Z, m_flags[2], S, m_flags[0]};
        endcase
      end
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clock);
    check_all(tag);
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit ev, input logic [W-1:0] res, input logic [4:0] ctl,
                       input logic [3:0] zcso, input logic [2:0] dst,
                       input bit desc, input bit sp);
    entrada_valida = ev;
    resultadoOp    = res;
    controle       = ctl;
    {Z, C, S, O}   = zcso;
    destino        = dst;
    descarte       = desc;
    saida_pronta   = sp;
  endtask

  task automatic idle(input bit sp);
    drive(1'b0, '0, 5'd0, 4'b0000, 3'd0, 1'b0, sp);
  endtask

  initial begin
    idle(1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single push, immediately drained
    drive(1'b1, 3'b000, 5'b00000, 4'b1100, 3'd2, 1'b0, 1'b1);
    tick("single_push");
    idle(1'b1);
    tick("single_out");
    tick("single_empty");

    // Backpressure to full, third push ignored, drain in order
    drive(1'b1, 3'b011, 5'b00000, 4'b0010, 3'd1, 1'b0, 1'b0);
    tick("bp_push1");
    drive(1'b1, 3'b111, 5'b00000, 4'b0001, 3'd3, 1'b0, 1'b0);
    tick("bp_push2");
    drive(1'b1, 3'b101, 5'b00000, 4'b1111, 3'd5, 1'b0, 1'b0);
    tick("bp_full_push");
    idle(1'b0);
    tick("bp_hold");
    idle(1'b1);
    tick("bp_pop1");
    tick("bp_pop2");
    tick("bp_empty");

    // Flag masking by operation class
    drive(1'b1, 3'b001, 5'b00000, 4'b1111, 3'd1, 1'b0, 1'b1);
    tick("flag_arit");
    drive(1'b1, 3'b010, 5'b10000, 4'b0010, 3'd2, 1'b0, 1'b1);
    tick("flag_logic");
    drive(1'b1, 3'b011, 5'b01000, 4'b0001, 3'd3, 1'b0, 1'b1);
    tick("flag_shift");
    drive(1'b1, 3'b100, 5'b11000, 4'b1111, 3'd4, 1'b0, 1'b1);
    tick("flag_logic2");
    idle(1'b1);
    tick("flag_drain");
    tick("flag_empty");

    // Streaming push+pop in UM
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, W'(i), 5'b00000, 4'(i), 3'(i + 2), 1'b0, 1'b1);
      tick("stream");
    end
    idle(1'b1);
    tick("stream_tail");
    tick("stream_empty");

    // Flush while full with concurrent push
    drive(1'b1, 3'b010, 5'b00000, 4'b0101, 3'd6, 1'b0, 1'b0);
    tick("fl_push1");
    drive(1'b1, 3'b110, 5'b00000, 4'b1010, 3'd7, 1'b0, 1'b0);
    tick("fl_push2");
    drive(1'b1, 3'b101, 5'b00000, 4'b1111, 3'd1, 1'b1, 1'b0);
    tick("fl_flush");
    idle(1'b0);
    tick("fl_after");
    // Flush with concurrent pop
    drive(1'b1, 3'b011, 5'b01000, 4'b1110, 3'd2, 1'b0, 1'b0);
    tick("fl_push3");
    drive(1'b0, 3'b000, 5'b00000, 4'b0000, 3'd0, 1'b1, 1'b1);
    tick("fl_flush_pop");
    idle(1'b1);
    tick("fl_after2");

    // Asynchronous reset between edges while full
    drive(1'b1, 3'b110, 5'b00000, 4'b1111, 3'd4, 1'b0, 1'b0);
    tick("rst_fill1");
    drive(1'b1, 3'b111, 5'b00000, 4'b1011, 3'd5, 1'b0, 1'b0);
    tick("rst_fill2");
    idle(1'b0);
    #2;
    reset_n = 1'b0;
    sb.delete();
    m_flags = 4'b0000;
    #1;
    check_all("rst_async");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    tick("rst_release1");
    drive(1'b1, 3'b001, 5'b00000, 4'b1000, 3'd1, 1'b0, 1'b0);
    tick("rst_first_push");
    idle(1'b1);
    tick("rst_out");
    tick("rst_empty");

    // Short random run against the model
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 5'($urandom), 4'($urandom),
            3'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      tick("random");
    end
    idle(1'b1);
    tick("final_drain1");
    tick("final_drain2");
    tick("final_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
